piso_bit_serializer: RTL and testbench
======================================

PISO_BIT_SERIALIZER -- requirements
Module: piso_bit_serializer

Interface
REQ-001 SHALL have parameter N, default 5, giving the parallel word width; legal range is N >= 2.
REQ-002 SHALL have derived localparam SEL_W, equal to $clog2(N), giving the width of the bit index.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a parallel word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, N bits: the parallel word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_bit is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_bit.
REQ-010 SHALL have port out_bit, output, 1 bit: the current serial bit.
REQ-011 SHALL have port out_last, output, 1 bit: the current beat is the final beat of the word.
REQ-012 SHALL have port sel, output, SEL_W bits: index of the data bit currently driven.
REQ-013 SHALL have port busy, output, 1 bit: high while a word is being serialized.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-015 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-016 In IDLE, when in_valid=1, SHALL register in_data into the word register, clear the beat counter, and go to SHIFT on the same edge.
REQ-017 In SHIFT: in_ready=0, out_valid=1, busy=1; in_valid is ignored.
REQ-018 The first data bit SHALL appear on out_bit in the cycle after acceptance (1-cycle latency).
REQ-019 Data bits SHALL be sent LSB first: beat k drives word[k], for k = 0..N-1.
REQ-020 The selected bit SHALL come from a combinational N:1 bit mux indexed by sel.
REQ-021 A beat SHALL complete only when out_valid=1 and out_ready=1; the counter advances by one per completed beat.
REQ-022 While out_ready=0, out_bit, sel and out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly on the final beat of the word.
REQ-024 Completion of the final beat SHALL return the FSM to IDLE, so there is one idle cycle between consecutive words.
REQ-025 The beat counter SHALL be $clog2(N+1) bits wide; sel SHALL never exceed N-1, including when N is not a power of two.
REQ-026 There is no path from out_ready to in_ready or any other combinational output-to-input path.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force: state=IDLE, word register=0, counter=0, sel=0, out_valid=0, out_last=0, out_bit=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-word SHALL discard the word in flight; no further beats of it are emitted after reset is released.
REQ-029 Reset release SHALL take effect at the first clk rising edge with rst_n=1.

Configuration
REQ-030 Macro SER_PARITY_EN defined: after the N data beats, the block SHALL emit one extra beat with out_bit = XOR of the word bits (even parity).
REQ-031 With SER_PARITY_EN defined, out_last SHALL be set on the parity beat only, and sel SHALL hold N-1 during that beat.
REQ-032 Macro SER_PARITY_EN undefined: the block SHALL emit exactly N beats, with out_last on beat N-1.

Structure
REQ-033 A shared package ser_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the counter-width helper constant and function.
REQ-034 The N:1 bit select SHALL be a separate sub-module, bit_mux, with parameter N, inputs w[N-1:0] and sel, and output out.

Verification
REQ-035 N=5, in_data=5'b10110, out_ready=1 throughout -> out_bit sequence 0,1,1,0,1 on consecutive cycles; sel sequence 0..4; out_last on beat 4; in_ready=1 the following cycle.
REQ-036 Same word with out_ready held low 3 cycles at beat 2 -> out_bit=1 and sel=2 held for 3 cycles, then the sequence resumes unchanged.
REQ-037 in_valid=1 with in_data=5'b11111 during SHIFT -> ignored; the current word completes intact; 5'b11111 is accepted only once back in IDLE.
REQ-038 rst_n pulsed low at beat 3 -> out_valid=0 and busy=0 immediately; after release, a new word 5'b00001 serializes as 1,0,0,0,0.
REQ-039 SER_PARITY_EN defined, in_data=5'b10110 -> 6 beats 0,1,1,0,1,1; out_last on beat 5 only.
REQ-040 N=4 without the macro, in_data=4'b1000 -> 4 beats 0,0,0,1; sel sequence 0..3 with no out-of-range value.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding, beat-count
// helpers and the optional parity-beat count.
// Optional feature macro: SER_PARITY_EN (appends one even-parity beat per word).
package ser_pkg;

    // Two-state FSM encoding, kept as plain constants for legacy tools.
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Number of beats emitted after the N data beats.
`ifdef SER_PARITY_EN
    localparam int PARITY_BEATS = 1;
`else
    localparam int PARITY_BEATS = 0;
`endif

    // Beat counter width: wide enough to hold the value N, which the parity
    // beat needs when it is enabled.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_mux.sv
// N:1 single-bit multiplexer. Index values >= N select 0; the serializer
// never drives such values, but the mux stays well defined for any N.
module bit_mux #(
    parameter int N = 5,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     w,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    // Pick the bit of w addressed by sel.
    always_comb begin
        // NOTE: assigning a default before any conditional keeps always_comb free of inferred latches.
        out = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                out = w[i];
            end
        end
    end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out bit serializer with valid/ready on both sides.
// A word accepted in IDLE is emitted LSB first, one bit per completed beat.
// Optional feature macro: SER_PARITY_EN (adds a trailing even-parity beat).
module piso_bit_serializer
    import ser_pkg::*;
#(
    parameter int N = 5,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1 + PARITY_BEATS);
    localparam logic [CNT_W-1:0] SEL_MAX   = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     word;
    logic [CNT_W-1:0] cnt;
    logic             data_bit;

    // FSM, word register and beat counter; a beat completes on valid && ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status flags depend on registered state only, so there is
    // no combinational path from out_ready or in_valid to any output.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign out_last  = (state == SHIFT) && (cnt == LAST_BEAT);

    // Bit index: follows the counter, clamped to N-1 for the parity beat.
    always_comb begin
        sel = cnt[SEL_W-1:0];
        if (cnt >= SEL_MAX) begin
            sel = SEL_W'(N - 1);
        end
    end

    bit_mux #(.N(N)) u_bit_mux (
        .w   (word),
        .sel (sel),
        .out (data_bit)
    );

    // Serial output, forced low outside SHIFT; parity replaces data on beat N.
    always_comb begin
        out_bit = 1'b0;
        if (state == SHIFT) begin
`ifdef SER_PARITY_EN
            out_bit = (cnt == CNT_W'(N)) ? ^word : data_bit;
`else
            out_bit = data_bit;
`endif
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer: the driver pushes the expected
// beat list of every accepted word, the monitor compares each presented beat.
module tb_piso_bit_serializer;

    localparam int N     = 5;
    localparam int SEL_W = $clog2(N);
`ifdef SER_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_bit;
    logic             out_last;
    logic [SEL_W-1:0] sel;
    logic             busy;

    typedef struct {
        logic b;
        int   idx;
        logic last;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    pending_first = 1'b0;
    bit    expect_idle = 1'b0;

    piso_bit_serializer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: LSB-first data beats, then an optional even-parity beat.
    task automatic push_word(input logic [N-1:0] d);
        int ones = 0;
        for (int k = 0; k < N; k++) begin
            sb.push_back('{b: d[k], idx: k, last: (k == N - 1) && !PARITY});
            ones += int'(d[k]);
        end
        if (PARITY) sb.push_back('{b: logic'(ones % 2), idx: N - 1, last: 1'b1});
    endtask

    // Advance to just after the next rising edge; confirm 1-cycle latency.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pending_first) begin
            check("first_beat_latency", 32'(out_valid), 32'd1);
            pending_first = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic r, output bit acc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc = v && in_ready;
        if (acc) begin
            push_word(d);
            pending_first = 1'b1;
        end
    endtask

    task automatic send_word(input logic [N-1:0] d);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            tick();
            drive(1'b1, d, 1'b1, acc);
        end
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic run_idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) begin
            tick();
            drive(1'b0, '0, 1'b1, acc);
        end
    endtask

    // Monitor: compare every presented beat with the scoreboard head; a
    // stalled beat is compared again each cycle, which checks it holds.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expect_idle = 1'b0;
            end else begin
                if (expect_idle) begin
                    check("idle_gap_out_valid", 32'(out_valid), 32'd0);
                    check("idle_gap_in_ready", 32'(in_ready), 32'd1);
                    expect_idle = 1'b0;
                end
                if (out_valid) begin
                    check("shift_in_ready", 32'(in_ready), 32'd0);
                    check("shift_busy", 32'(busy), 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 32'(out_valid), 32'd0);
                    end else begin
                        check("out_bit", 32'(out_bit), 32'(sb[0].b));
                        check("sel", 32'(sel), 32'(sb[0].idx));
                        check("out_last", 32'(out_last), 32'(sb[0].last));
                        if (out_ready) begin
                            if (sb[0].last) expect_idle = 1'b1;
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    check("idle_in_ready", 32'(in_ready), 32'd1);
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_out_last", 32'(out_last), 32'd0);
                end
            end
        end
    end

    initial begin
        bit acc;
        int stall_left;
        bit done;

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_idle(2);

        // Plain word with downstream always ready
        send_word(5'b10110);
        run_idle(N + 3);

        // Stall for three cycles while beat 2 is presented
        send_word(5'b10110);
        stall_left = 3;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (out_valid && sel == SEL_W'(2) && stall_left > 0) begin
                drive(1'b0, '0, 1'b0, acc);
                stall_left--;
            end else begin
                drive(1'b0, '0, 1'b1, acc);
            end
            done = (stall_left == 0) && (sb.size() == 0);
        end
        check("stall_word_done", 32'(done), 32'd1);
        run_idle(2);

        // in_valid during SHIFT is ignored; 11111 is taken only once idle
        send_word(5'b10110);
        send_word(5'b11111);
        run_idle(N + 3);

        // Reset in the middle of a word discards it
        send_word(5'b10110);
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            done = out_valid && (sel == SEL_W'(3));
            if (!done) drive(1'b0, '0, 1'b1, acc);
        end
        check("reach_beat3", 32'(done), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        sb.delete();
        pending_first = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(5'b00001);
        run_idle(N + 3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            drive(logic'($urandom_range(1)), N'($urandom), logic'($urandom_range(3) != 0), acc);
        end

        // Drain whatever is still in flight
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            drive(1'b0, '0, 1'b1, acc);
            done = (sb.size() == 0) && !out_valid;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        run_idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
